// File: rtl/irst_ctrl_if.sv
// Host register bus between the core's host port and irst_ctrl.
// Single-cycle read/write strobes; read data comes back one cycle later.
interface irst_ctrl_if;
  logic        host_wr_en;
  logic        host_rd_en;
  logic [1:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;

  modport master (
    output host_wr_en,
    output host_rd_en,
    output host_addr,
    output host_wdata,
    input  host_rdata
  );

  modport slave (
    input  host_wr_en,
    input  host_rd_en,
    input  host_addr,
    input  host_wdata,
    output host_rdata
  );
endinterface

// File: rtl/irst_ctrl.sv
// Host controller for the IF-stage instruction-rotation self-test:
// drives the control word, times each run, reports status and irq.
module irst_ctrl #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000,
  parameter int          PC_LIMIT_W     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  irst_ctrl_if.slave        host,
  output logic [15:0]       irst_reg_data,
  input  logic              irst_done,
  output logic              irq
);

  localparam int PASS_W = 13 - PC_LIMIT_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_n;

  logic                  cfg_irq_en;
  logic [PC_LIMIT_W-1:0] cfg_limit;
  logic [PASS_W-1:0]     cfg_pass;
  logic [PC_LIMIT_W-1:0] sh_limit;
  logic [PASS_W-1:0]     sh_pass;
  logic [PC_LIMIT_W-1:0] lim_n;
  logic [PASS_W-1:0]     pass_n;

  logic        f_done, f_to, f_err, f_abt;
  logic [15:0] cycles;
  logic [15:0] word_n;
  logic [15:0] rd_val;

  logic wr_cfg, wr_ctl, wr_sts;
  logic start, abort, busy, to_hit;
  logic [3:0] w1c;
  logic set_done, set_to, set_err, set_abt, load;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, host.host_wdata[7:6]};

  assign wr_cfg = host.host_wr_en && (host.host_addr == 2'd0);
  assign wr_ctl = host.host_wr_en && (host.host_addr == 2'd1);
  assign wr_sts = host.host_wr_en && (host.host_addr == 2'd2);

  // Abort dominates a start carried in the same CTRL write.
  assign abort = wr_ctl & host.host_wdata[1];
  assign start = wr_ctl & host.host_wdata[0] & ~host.host_wdata[1];
  assign w1c   = wr_sts ? host.host_wdata[4:1] : 4'b0000;
  assign busy  = (state != IDLE);

  assign to_hit = (TIMEOUT_CYCLES != 16'd0) &&
                  ((cycles + 16'd1) == TIMEOUT_CYCLES);

  always_comb begin
    state_n  = state;
    set_done = 1'b0;
    set_to   = 1'b0;
    set_err  = 1'b0;
    set_abt  = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cfg_limit != '0) begin
            load    = 1'b1;
            state_n = RUN;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      RUN: begin
        set_err = start;
        if (irst_done) begin
          set_done = 1'b1;
          state_n  = RELEASE;
        end else if (to_hit) begin
          set_to  = 1'b1;
          state_n = IDLE;
        end else if (abort) begin
          set_abt = 1'b1;
          state_n = IDLE;
        end
      end
      RELEASE: begin
        set_err = start;
        if (!irst_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control word is computed from the next state so it is a pure flop.
  always_comb begin
    lim_n  = load ? cfg_limit : sh_limit;
    pass_n = load ? cfg_pass  : sh_pass;
    word_n = '0;
    unique case (state_n)
      RUN:     word_n = {1'b1, lim_n, 2'b00, pass_n};
      RELEASE: word_n = {1'b0, lim_n, 2'b00, pass_n};
      default: word_n = '0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    unique case (host.host_addr)
      2'd0: rd_val = {cfg_irq_en, cfg_limit, 2'b00, cfg_pass};
      2'd1: rd_val = '0;
      2'd2: rd_val = {11'd0, f_abt, f_err, f_to, f_done, busy};
      default: rd_val = cycles;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_irq_en <= 1'b0;
      cfg_limit  <= '0;
      cfg_pass   <= '0;
    end else if (wr_cfg) begin
      cfg_irq_en <= host.host_wdata[15];
      cfg_limit  <= host.host_wdata[8 +: PC_LIMIT_W];
      cfg_pass   <= host.host_wdata[PASS_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_limit <= '0;
      sh_pass  <= '0;
      cycles   <= '0;
    end else if (load) begin
      sh_limit <= cfg_limit;
      sh_pass  <= cfg_pass;
      cycles   <= '0;
    end else if (state == RUN && cycles != 16'hFFFF) begin
      cycles <= cycles + 16'd1;
    end
  end

  // Hardware set wins over a W1C in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_done <= 1'b0;
      f_to   <= 1'b0;
      f_err  <= 1'b0;
      f_abt  <= 1'b0;
    end else begin
      f_done <= (f_done & ~w1c[0]) | set_done;
      f_to   <= (f_to   & ~w1c[1]) | set_to;
      f_err  <= (f_err  & ~w1c[2]) | set_err;
      f_abt  <= (f_abt  & ~w1c[3]) | set_abt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irst_reg_data   <= '0;
      irq             <= 1'b0;
      host.host_rdata <= '0;
    end else begin
      irst_reg_data <= word_n;
      irq <= cfg_irq_en & (f_done | f_to | f_err | f_abt);
      if (host.host_rd_en) host.host_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_irst_ctrl.sv
// Bench for irst_ctrl: directed and random runs, reads checked
// through a scoreboard queue drained by a separate monitor.
module tb_irst_ctrl;
  localparam logic [15:0] TO = 16'd100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irst_done = 1'b0;
  logic [15:0] irst_reg_data;
  logic        irq;

  irst_ctrl_if bus();

  irst_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .PC_LIMIT_W(7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host(bus.slave),
    .irst_reg_data(irst_reg_data),
    .irst_done(irst_done),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic        rd_pend;

  task automatic check(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_pend <= 1'b0;
    else rd_pend <= bus.host_rd_en;

  always @(negedge clk)
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rd_unexpected: got %h want none", bus.host_rdata);
      end else begin
        check(tag_q.pop_front(), bus.host_rdata, exp_q.pop_front());
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.host_wr_en = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    tick();
    bus.host_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e,
                    input string nm);
    bus.host_rd_en = 1'b1;
    bus.host_addr  = a;
    exp_q.push_back(e);
    tag_q.push_back(nm);
    tick();
    bus.host_rd_en = 1'b0;
  endtask

  function automatic logic [15:0] word_on(input logic [15:0] c);
    return {1'b1, c[14:8], 2'b00, c[5:0]};
  endfunction

  // mode 0: fetch reports done after len cycles; 1: abort; 2: timeout
  task automatic run(input logic [15:0] cfg, input int mode,
                     input int len);
    logic [15:0] on, fl;
    int cnt, cyc;
    wr(2'd0, cfg);
    rd(2'd0, cfg & 16'hFF3F, "cfg_rb");
    wr(2'd1, 16'h0001);
    on = word_on(cfg);
    check("en_run", irst_reg_data, on);
    fl = 16'h0;
    cyc = 0;
    case (mode)
      0: begin
        repeat (len - 1) tick();
        irst_done = 1'b1;
        tick();
        check("release_word", irst_reg_data, on & 16'h7FFF);
        rd(2'd2, 16'h0003, "sts_release");
        irst_done = 1'b0;
        tick();
        check("idle_word", irst_reg_data, 16'h0000);
        fl = 16'h0002;
        cyc = len;
      end
      1: begin
        repeat (len - 1) tick();
        wr(2'd1, 16'h0002);
        check("abort_word", irst_reg_data, 16'h0000);
        fl = 16'h0010;
        cyc = len;
      end
      default: begin
        cnt = 0;
        while (irst_reg_data[15] && cnt < 300) begin
          cnt++;
          tick();
        end
        check("to_len", cnt[15:0], TO);
        fl = 16'h0004;
        cyc = int'(TO);
      end
    endcase
    rd(2'd2, fl, "sts_flag");
    rd(2'd3, cyc[15:0], "cycles");
    check("irq_set", {15'd0, irq}, {15'd0, cfg[15]});
    wr(2'd2, fl);
    tick();
    rd(2'd2, 16'h0000, "sts_clr");
    check("irq_clr", {15'd0, irq}, 16'h0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] cfg;
    int sz;
    bus.host_wr_en = 1'b0;
    bus.host_rd_en = 1'b0;
    bus.host_addr  = 2'd0;
    bus.host_wdata = 16'h0;
    repeat (3) tick();
    check("rst_word", irst_reg_data, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    check("rst_rdata", bus.host_rdata, 16'h0000);
    rst_n = 1'b1;
    tick();
    rd(2'd0, 16'h0000, "rst_cfg");
    rd(2'd1, 16'h0000, "rst_ctrl");
    rd(2'd2, 16'h0000, "rst_sts");
    rd(2'd3, 16'h0000, "rst_cyc");

    run(16'h8A05, 0, 50);

    wr(2'd0, 16'h0005);
    wr(2'd1, 16'h0001);
    check("lim0_word", irst_reg_data, 16'h0000);
    tick();
    rd(2'd2, 16'h0008, "lim0_err");
    check("lim0_irq", {15'd0, irq}, 16'h0000);
    wr(2'd2, 16'h0008);

    run(16'h1203, 2, 0);

    run(16'h0A05, 1, 10);
    wr(2'd1, 16'h0003);
    check("sa_idle_word", irst_reg_data, 16'h0000);
    tick();
    rd(2'd2, 16'h0000, "sa_idle_sts");
    rd(2'd3, 16'd10, "sa_idle_cyc");
    rd(2'd1, 16'h0000, "ctrl_rd0");

    wr(2'd0, 16'h8A05);
    wr(2'd1, 16'h0001);
    tick();
    wr(2'd0, 16'h0101);
    wr(2'd1, 16'h0001);
    check("busy_cfg_word", irst_reg_data, 16'h8A05);
    rd(2'd2, 16'h0009, "busy_err");
    rd(2'd0, 16'h0101, "cfg_new");
    wr(2'd1, 16'h0002);
    rd(2'd2, 16'h0018, "err_abt");
    wr(2'd2, 16'h001E);
    run(16'h0101, 0, 5);

    repeat (16) begin
      cfg = 16'($urandom);
      if (cfg[14:8] == 7'd0) cfg[8] = 1'b1;
      run(cfg, int'($urandom_range(0, 2)), int'($urandom_range(1, 60)));
    end

    wr(2'd0, 16'h8A05);
    wr(2'd1, 16'h0001);
    repeat (3) tick();
    irst_done = 1'b1;
    wr(2'd2, 16'h0002);
    rd(2'd2, 16'h0003, "collide_sts");
    check("collide_irq", {15'd0, irq}, 16'h0001);
    irst_done = 1'b0;
    tick();
    wr(2'd2, 16'h0002);
    wr(2'd1, 16'h0001);
    repeat (5) tick();
    wr(2'd1, 16'h0001);
    repeat (2) tick();
    check("pre_rst_irq", {15'd0, irq}, 16'h0001);
    rd(2'd3, 16'd8, "cyc_live");
    #6;
    rst_n = 1'b0;
    #1;
    check("arst_word", irst_reg_data, 16'h0000);
    check("arst_irq", {15'd0, irq}, 16'h0000);
    check("arst_rdata", bus.host_rdata, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rd(2'd0, 16'h0000, "post_cfg");
    rd(2'd2, 16'h0000, "post_sts");
    rd(2'd3, 16'h0000, "post_cyc");
    repeat (3) tick();
    sz = exp_q.size();
    check("sb_drain", sz[15:0], 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
